pipeline_control_sequencer: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Combines the hazard unit's load-use and branch indications with the data-memory handshake and halt opcode, and drives the PC and pipeline-register write enables, flushes and freeze. Keeps saturating stall/flush statistics for debug. Sits between the hazard detection unit and every pipeline register plus the PC.

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_control_sequencer_sat_counter.sv | 13 +
 rtl/pipeline_control_sequencer.sv | 111 +++++++++++
 tb/tb_pipeline_control_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding, opcodes and parameter limits for the stall/flush sequencer.
package pipeline_ctrl_pkg;
  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    FLUSH      = 3'd2,
    MEM_WAIT   = 3'd3,
    HALTED     = 3'd4
  } state_t;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam int FLUSH_MIN = 1;
  localparam int FLUSH_MAX = 3;
  localparam int TIMEOUT_MIN = 1;
  localparam int TIMEOUT_MAX = 255;
  localparam int TIMER_W = 8;
endpackage

// File: rtl/pipeline_control_sequencer_sat_counter.sv
// sat_counter: increment-by-one statistics counter that sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_control_sequencer.sv
// pipeline_control_sequencer: central stall/flush sequencer driving PC and pipeline-register enables.
module pipeline_control_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic [3:0]       instop,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [2:0]       state
);
  if (FLUSH_CYCLES < FLUSH_MIN || FLUSH_CYCLES > FLUSH_MAX) begin : g_bad_flush
    $error("FLUSH_CYCLES out of range");
  end
  if (MEM_TIMEOUT < TIMEOUT_MIN || MEM_TIMEOUT > TIMEOUT_MAX) begin : g_bad_timeout
    $error("MEM_TIMEOUT out of range");
  end
  state_t st, nxt;
  logic [TIMER_W-1:0] timer, t_nxt;
  logic [1:0] fcnt, f_nxt;
  logic to_set, fl_inc, st_inc;
  always_comb begin
    pc_write = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold = 1'b0;
    halted = 1'b0;
    nxt = st;
    t_nxt = timer;
    f_nxt = fcnt;
    to_set = 1'b0;
    fl_inc = 1'b0;
    if (st == HALTED) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      pipe_hold = 1'b1;
      halted = 1'b1;
    end else if (st == MEM_WAIT) begin
      if (mem_ack) nxt = RUN;
      else begin
        pc_write = 1'b0;
        ifid_write = 1'b0;
        pipe_hold = 1'b1;
        t_nxt = timer + 1'b1;
        if (timer == TIMER_W'(MEM_TIMEOUT - 1)) begin
          nxt = HALTED;
          to_set = 1'b1;
        end
      end
    end else if (mem_req && !mem_ack) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      pipe_hold = 1'b1;
      t_nxt = '0;
      nxt = MEM_WAIT;
    end else if (instop == OP_HALT) begin
      pc_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      nxt = HALTED;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      fl_inc = 1'b1;
      f_nxt = 2'(FLUSH_CYCLES - 1);
      nxt = FLUSH_CYCLES > 1 ? FLUSH : RUN;
    end else if (load_use && st == RUN) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      nxt = LOAD_STALL;
    end else if (st == FLUSH) begin
      ifid_flush = 1'b1;
      f_nxt = fcnt - 1'b1;
      nxt = fcnt == 2'd1 ? RUN : FLUSH;
    end else nxt = RUN;
  end
  // the cycle that commits to HALTED is excluded from stall statistics
  assign st_inc = !pc_write && st != HALTED && nxt != HALTED;
  assign state = st;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st <= RUN;
      timer <= '0;
      fcnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      st <= nxt;
      timer <= t_nxt;
      fcnt <= f_nxt;
      if (to_set) mem_timeout <= 1'b1;
    end
  sat_counter #(.WIDTH(CNT_W)) u_stall (.clock(clock), .reset_n(reset_n), .inc(st_inc), .count(stall_count));
  sat_counter #(.WIDTH(CNT_W)) u_flush (.clock(clock), .reset_n(reset_n), .inc(fl_inc), .count(flush_count));
endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// tb_pipeline_control_sequencer: directed scenarios with hand-computed expectations.
module tb_pipeline_control_sequencer;
  logic clock = 1'b0, reset_n = 1'b0;
  logic load_use = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic [3:0] instop = 4'd0;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, halted, mem_timeout;
  logic [15:0] stall_count, flush_count;
  logic [2:0] state;
  int total = 0, bad = 0;

  pipeline_control_sequencer #(.CNT_W(16), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .load_use(load_use), .branch_taken(branch_taken),
    .instop(instop), .mem_req(mem_req), .mem_ack(mem_ack), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_hold(pipe_hold), .halted(halted), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count), .state(state));

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    load_use = 0; branch_taken = 0; mem_req = 0; mem_ack = 0; instop = 4'd0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    repeat (2) cyc();
    reset_n = 1;
    repeat (5) cyc();
    total++; if ({pc_write, ifid_write} !== 2'b11) begin bad++; $display("FAIL reset_en got=%b exp=11", {pc_write, ifid_write}); end
    total++; if ({ifid_flush, idex_flush, pipe_hold, halted, mem_timeout} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=00000", {ifid_flush, idex_flush, pipe_hold, halted, mem_timeout}); end
    total++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_count, flush_count); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
  endtask

  task automatic test_load_use();
    load_use = 1; #1;
    total++; if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b0010) begin bad++; $display("FAIL lu_c1 got=%b exp=0010", {pc_write, ifid_write, idex_flush, ifid_flush}); end
    cyc();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL lu_state got=%0d exp=1", state); end
    total++; if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin bad++; $display("FAIL lu_c2 got=%b exp=110", {pc_write, ifid_write, idex_flush}); end
    cyc();
    idle(); #1;
    total++; if (state !== 3'd0 || stall_count !== 16'd1) begin bad++; $display("FAIL lu_done got=%0d/%0d exp=0/1", state, stall_count); end
  endtask

  task automatic test_branch();
    branch_taken = 1; load_use = 1; #1;
    total++; if ({pc_write, ifid_write, ifid_flush, idex_flush} !== 4'b1111) begin bad++; $display("FAIL br_c1 got=%b exp=1111", {pc_write, ifid_write, ifid_flush, idex_flush}); end
    cyc();
    branch_taken = 0; #1;
    total++; if (state !== 3'd2) begin bad++; $display("FAIL br_state got=%0d exp=2", state); end
    total++; if ({pc_write, ifid_flush, idex_flush} !== 3'b110) begin bad++; $display("FAIL br_c2 got=%b exp=110", {pc_write, ifid_flush, idex_flush}); end
    cyc();
    idle(); #1;
    total++; if (state !== 3'd0 || ifid_flush !== 1'b0) begin bad++; $display("FAIL br_done got=%0d/%b exp=0/0", state, ifid_flush); end
    total++; if (flush_count !== 16'd1 || stall_count !== 16'd1) begin bad++; $display("FAIL br_cnt got=%0d/%0d exp=1/1", flush_count, stall_count); end
  endtask

  task automatic test_mem_wait();
    mem_req = 1; #1;
    total++; if ({pipe_hold, pc_write, ifid_write} !== 3'b100) begin bad++; $display("FAIL mw_c0 got=%b exp=100", {pipe_hold, pc_write, ifid_write}); end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      total++; if (state !== 3'd3 || pipe_hold !== 1'b1) begin bad++; $display("FAIL mw_hold%0d got=%0d/%b exp=3/1", i, state, pipe_hold); end
    end
    cyc();
    mem_ack = 1; #1;
    total++; if ({pipe_hold, pc_write, ifid_write} !== 3'b011) begin bad++; $display("FAIL mw_ack got=%b exp=011", {pipe_hold, pc_write, ifid_write}); end
    cyc();
    idle(); #1;
    total++; if (state !== 3'd0 || stall_count !== 16'd5 || mem_timeout !== 1'b0) begin bad++; $display("FAIL mw_done got=%0d/%0d/%b exp=0/5/0", state, stall_count, mem_timeout); end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1;
    cyc();
    #1;
    total++; if ({ifid_flush, idex_flush, state} !== 5'b11010) begin bad++; $display("FAIL b2b_c2 got=%b exp=11010", {ifid_flush, idex_flush, state}); end
    cyc();
    branch_taken = 0; #1;
    total++; if ({ifid_flush, idex_flush, state} !== 5'b10010) begin bad++; $display("FAIL b2b_c3 got=%b exp=10010", {ifid_flush, idex_flush, state}); end
    cyc();
    mem_req = 1; mem_ack = 1; #1;
    total++; if ({pc_write, pipe_hold, ifid_flush, state} !== 6'b100000) begin bad++; $display("FAIL b2b_reqack got=%b exp=100000", {pc_write, pipe_hold, ifid_flush, state}); end
    cyc();
    idle(); #1;
    total++; if (flush_count !== 16'd3 || stall_count !== 16'd5 || state !== 3'd0) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d/%0d exp=3/5/0", flush_count, stall_count, state); end
  endtask

  task automatic test_reset_mid_flush();
    branch_taken = 1;
    cyc();
    branch_taken = 0;
    reset_n = 0; #1;
    total++; if ({state, ifid_flush, pc_write} !== 5'b00001) begin bad++; $display("FAIL rst_flush got=%b exp=00001", {state, ifid_flush, pc_write}); end
    total++; if (flush_count !== 16'd0 || stall_count !== 16'd0) begin bad++; $display("FAIL rst_flush_cnt got=%0d/%0d exp=0/0", flush_count, stall_count); end
    #2 reset_n = 1;
    cyc();
  endtask

  task automatic test_timeout();
    mem_req = 1;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      total++; if (state !== 3'd3 || mem_timeout !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%0d/%b/%b exp=3/0/0", i, state, mem_timeout, halted); end
      cyc();
    end
    total++; if ({state, halted, mem_timeout} !== 5'b10011) begin bad++; $display("FAIL to_halt got=%b exp=10011", {state, halted, mem_timeout}); end
    mem_ack = 1; branch_taken = 1;
    repeat (3) cyc();
    total++; if ({state, halted, mem_timeout, pc_write, pipe_hold} !== 7'b1001101) begin bad++; $display("FAIL to_stay got=%b exp=1001101", {state, halted, mem_timeout, pc_write, pipe_hold}); end
    total++; if (stall_count !== 16'd4 || flush_count !== 16'd0) begin bad++; $display("FAIL to_cnt got=%0d/%0d exp=4/0", stall_count, flush_count); end
    idle();
    reset_n = 0; #1;
    total++; if ({mem_timeout, halted, state, pc_write} !== 6'b000001) begin bad++; $display("FAIL to_rst got=%b exp=000001", {mem_timeout, halted, state, pc_write}); end
    #2 reset_n = 1;
    cyc();
  endtask

  task automatic test_halt();
    instop = 4'b1111; #1;
    total++; if ({pc_write, ifid_flush, idex_flush, halted} !== 4'b0110) begin bad++; $display("FAIL halt_c0 got=%b exp=0110", {pc_write, ifid_flush, idex_flush, halted}); end
    cyc();
    instop = 4'd0; branch_taken = 1; load_use = 1; #1;
    total++; if ({state, halted, pc_write, ifid_write, pipe_hold} !== 7'b1001001) begin bad++; $display("FAIL halt_st got=%b exp=1001001", {state, halted, pc_write, ifid_write, pipe_hold}); end
    repeat (2) cyc();
    total++; if (stall_count !== 16'd0 || flush_count !== 16'd0 || state !== 3'd4) begin bad++; $display("FAIL halt_cnt got=%0d/%0d/%0d exp=0/0/4", stall_count, flush_count, state); end
    idle();
    reset_n = 0; #1;
    total++; if ({state, halted, pc_write, ifid_write, pipe_hold} !== 7'b0000110) begin bad++; $display("FAIL halt_rst got=%b exp=0000110", {state, halted, pc_write, ifid_write, pipe_hold}); end
    #2 reset_n = 1;
    cyc();
    total++; if (state !== 3'd0 || stall_count !== 16'd0) begin bad++; $display("FAIL halt_after got=%0d/%0d exp=0/0", state, stall_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_reset_mid_flush();
    test_timeout();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
